// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 stream demultiplexer.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel of the demultiplexer.
module demux_slot #(
    parameter int DATA_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    // A load wins over a drain so a word can stream in while the previous one leaves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (i_drain) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 stream demultiplexer: routes each accepted word into one of
// four one-entry output slots, with per-channel back-pressure and an accept counter.
module demux1to4_reg
    import demux_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic [DATA_W-1:0]        i_data,
    output logic [NUM_CH-1:0]        o_valid,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    input  logic [NUM_CH-1:0]        i_ready,
    output logic [CNT_W-1:0]         o_count
);

    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drain;

    // The addressed slot can take a word if it is empty or being emptied this cycle.
    assign o_ready = !o_valid[i_sel] || i_ready[i_sel];
    assign accept  = i_valid && o_ready;
    assign drain   = o_valid & i_ready;

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_slot
            assign load[n] = accept && (i_sel == sel_t'(n));

            demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_load  (load[n]),
                .i_drain (drain[n]),
                .i_data  (i_data),
                .o_valid (o_valid[n]),
                .o_data  (o_data[n*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (accept) begin
            o_count <= o_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux1to4_reg.sv
// Self-checking bench for demux1to4_reg: directed scenarios plus randomized traffic
// compared against a per-channel queue model of the routing rules.
module tb_demux1to4_reg;
    localparam int DATA_W = 2;
    localparam int CNT_W  = 8;

    logic                clk;
    logic                rst;
    logic                valid_in;
    logic                ready_out;
    logic [1:0]          sel;
    logic [DATA_W-1:0]   data_in;
    logic [3:0]          valid_out;
    logic [4*DATA_W-1:0] data_out;
    logic [3:0]          ready_in;
    logic [CNT_W-1:0]    count;

    int vectors;
    int miscompares;

    // Model: each channel is a queue holding at most one word; last_out remembers
    // the most recent word so the held output value after a drain is known.
    int ch_q[4][$];
    int last_out[4];
    int model_count;

    demux1to4_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_sel   (sel),
        .i_data  (data_in),
        .o_valid (valid_out),
        .o_data  (data_out),
        .i_ready (ready_in),
        .o_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return (ch_q[sel].size() == 0) || ready_in[sel];
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = (ch_q[n].size() != 0);
        return v;
    endfunction

    function automatic logic [4*DATA_W-1:0] exp_data();
        logic [4*DATA_W-1:0] d;
        for (int n = 0; n < 4; n++)
            d[n*DATA_W +: DATA_W] = (ch_q[n].size() != 0) ? DATA_W'(ch_q[n][0]) : DATA_W'(last_out[n]);
        return d;
    endfunction

    task automatic set_inputs(input logic r, input logic v, input logic [1:0] s,
                              input logic [DATA_W-1:0] d, input logic [3:0] rdy);
        rst      = r;
        valid_in = v;
        sel      = s;
        data_in  = d;
        ready_in = rdy;
        #1;
    endtask

    // Advances one clock and applies the routing rules to the model.
    task automatic clock_step();
        bit accepted;
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                ch_q[n].delete();
                last_out[n] = 0;
            end
            model_count = 0;
        end else begin
            accepted = valid_in && ((ch_q[sel].size() == 0) || ready_in[sel]);
            for (int n = 0; n < 4; n++)
                if (ch_q[n].size() != 0 && ready_in[n]) last_out[n] = ch_q[n].pop_front();
            if (accepted) begin
                ch_q[sel].push_back(int'(data_in));
                last_out[sel] = int'(data_in);
                model_count = (model_count + 1) % (1 << CNT_W);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_inputs(1'b1, 1'b0, 2'd0, '0, 4'b0000);
        clock_step();
        set_inputs(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 1'b1, 2'd2, 2'd3, 4'b1111);
        clock_step();
        set_inputs(1'b0, 1'b0, 2'd0, '0, 4'b0000);
        vectors++;
        if (valid_out !== 4'b0000 || data_out !== '0 || count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got valid=%b data=%h count=%0d, expected 0000/0/0",
                     valid_out, data_out, count);
        end
        for (int s = 0; s < 4; s++) begin
            set_inputs(1'b0, 1'b0, 2'(s), '0, 4'b0000);
            vectors++;
            if (ready_out !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reset_ready sel=%0d: got %b expected 1", s, ready_out);
            end
        end
    endtask

    task automatic test_route();
        do_reset();
        for (int s = 0; s < 4; s++) begin
            set_inputs(1'b0, 1'b1, 2'(s), 2'(s), 4'b1111);
            clock_step();
            vectors++;
            if (valid_out !== (4'b0001 << s) || data_out[s*DATA_W +: DATA_W] !== 2'(s)) begin
                miscompares++;
                $display("[TB] FAIL route ch%0d: got valid=%b data=%h expected valid=%b word=%0d",
                         s, valid_out, data_out, 4'b0001 << s, s);
            end
        end
        vectors++;
        if (count !== 8'd4) begin
            miscompares++;
            $display("[TB] FAIL route_count: got %0d expected 4", count);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        set_inputs(1'b0, 1'b1, 2'd2, 2'b10, 4'b1011);
        clock_step();
        set_inputs(1'b0, 1'b1, 2'd2, 2'b11, 4'b1011);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (ready_out !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_stall cycle %0d: got ready=%b expected 0", k, ready_out);
            end
            clock_step();
        end
        vectors++;
        if (valid_out[2] !== 1'b1 || data_out[4 +: 2] !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: got valid2=%b data2=%b expected 1/10", valid_out[2], data_out[4 +: 2]);
        end
        set_inputs(1'b0, 1'b1, 2'd2, 2'b11, 4'b1111);
        vectors++;
        if (ready_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_release_ready: got %b expected 1", ready_out);
        end
        clock_step();
        set_inputs(1'b0, 1'b0, 2'd0, '0, 4'b0000);
        vectors++;
        if (valid_out[2] !== 1'b1 || data_out[4 +: 2] !== 2'b11 || count !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got valid2=%b data2=%b count=%0d expected 1/11/2",
                     valid_out[2], data_out[4 +: 2], count);
        end
    endtask

    task automatic test_independence();
        do_reset();
        set_inputs(1'b0, 1'b1, 2'd1, 2'b10, 4'b0000);
        clock_step();
        set_inputs(1'b0, 1'b1, 2'd3, 2'b01, 4'b0000);
        vectors++;
        if (ready_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL indep_ready: got %b expected 1", ready_out);
        end
        clock_step();
        set_inputs(1'b0, 1'b0, 2'd0, '0, 4'b0000);
        vectors++;
        if (valid_out !== 4'b1010 || data_out[6 +: 2] !== 2'b01 || data_out[2 +: 2] !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL indep_state: got valid=%b data=%h expected valid=1010 ch3=01 ch1=10",
                     valid_out, data_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_inputs(1'b0, 1'b1, 2'd0, 2'(k), 4'b0001);
            vectors++;
            if (ready_out !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_ready word %0d: got %b expected 1", k, ready_out);
            end
            clock_step();
            vectors++;
            if (valid_out[0] !== 1'b1 || data_out[0 +: 2] !== 2'(k)) begin
                miscompares++;
                $display("[TB] FAIL b2b word %0d: got valid0=%b data0=%0d expected 1/%0d",
                         k, valid_out[0], data_out[0 +: 2], k);
            end
        end
        set_inputs(1'b0, 1'b0, 2'd0, '0, 4'b0001);
        clock_step();
        vectors++;
        if (valid_out[0] !== 1'b0 || data_out[0 +: 2] !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL b2b_drain: got valid0=%b data0=%0d expected 0/3", valid_out[0], data_out[0 +: 2]);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int k = 0; k < 256; k++) begin
            set_inputs(1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom), 4'b1111);
            clock_step();
        end
        vectors++;
        if (count !== 8'd0 || model_count != 0) begin
            miscompares++;
            $display("[TB] FAIL wrap_256: got %0d expected 0", count);
        end
        set_inputs(1'b0, 1'b1, 2'd1, 2'd1, 4'b1111);
        clock_step();
        vectors++;
        if (count !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap_257: got %0d expected 1", count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_inputs(1'b0, 1'b1, 2'd0, 2'd3, 4'b0000);
        clock_step();
        set_inputs(1'b0, 1'b1, 2'd2, 2'd1, 4'b0000);
        clock_step();
        vectors++;
        if (valid_out !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL mid_prefill: got valid=%b expected 0101", valid_out);
        end
        set_inputs(1'b1, 1'b1, 2'd1, 2'd2, 4'b1111);
        clock_step();
        set_inputs(1'b0, 1'b0, 2'd0, '0, 4'b0000);
        vectors++;
        if (valid_out !== 4'b0000 || data_out !== '0 || count !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got valid=%b data=%h count=%0d expected 0000/0/0",
                     valid_out, data_out, count);
        end
    endtask

    // Random traffic; a refused word is held stable until it is accepted.
    task automatic test_random();
        logic            v;
        logic [1:0]      s;
        logic [DATA_W-1:0] d;
        logic            pending;
        do_reset();
        pending = 1'b0;
        v = 1'b0;
        s = '0;
        d = '0;
        for (int k = 0; k < 400; k++) begin
            if (!pending) begin
                v = ($urandom_range(0, 3) != 0);
                s = 2'($urandom_range(0, 3));
                d = DATA_W'($urandom);
            end
            set_inputs(1'b0, v, s, d, 4'($urandom));
            vectors++;
            if (ready_out !== exp_ready()) begin
                miscompares++;
                $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", k, ready_out, exp_ready());
            end
            pending = v && !exp_ready();
            clock_step();
            vectors++;
            if (valid_out !== exp_valid() || data_out !== exp_data() || count !== CNT_W'(model_count)) begin
                miscompares++;
                $display("[TB] FAIL rand_state cycle %0d: got valid=%b data=%h count=%0d expected valid=%b data=%h count=%0d",
                         k, valid_out, data_out, count, exp_valid(), exp_data(), model_count);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_count = 0;
        for (int n = 0; n < 4; n++) last_out[n] = 0;
        set_inputs(1'b1, 1'b0, 2'd0, '0, 4'b0000);
        test_reset();
        test_route();
        test_back_pressure();
        test_independence();
        test_back_to_back();
        test_counter_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
